// File: rtl/tx_arbiter.sv
// Round-robin scheduler sharing one byte-serial UART TX controller among NUM_REQ producers.
// Optional completion watchdog is compiled in with `define TX_ARB_WATCHDOG_EN.
module tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   system_clk,
    input  logic                   system_reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic [NUM_REQ-1:0]     error,
    output logic                   arb_busy,
    output logic [7:0]             tx_data_byte,
    output logic                   tx_start_signal,
    input  logic                   tx_busy_flag,
    input  logic                   tx_complete_flag
);

    // state      | meaning
    // S_IDLE     | no transfer owned; arbitrate when a request is pending and the controller is idle
    // S_START    | owner latched; tx_start_signal high for this single cycle
    // S_WAIT_DONE| waiting for the controller's completion pulse (or watchdog expiry)

    localparam int PTR_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [NUM_REQ-1:0]   err_q, err_d;
    logic                 busy_q, busy_d;
    logic [7:0]           data_q, data_d;
    logic                 start_q, start_d;

    logic                 found;
    logic [PTR_W-1:0]     win_idx;
    logic [PTR_W-1:0]     win_next;
    logic                 arb_win;
    logic                 wd_expired;

`ifdef TX_ARB_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wd_q, wd_d;
    assign wd_expired = (wd_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign wd_expired = 1'b0;
`endif

    // First pending request at or above ptr, wrapping explicitly for non power-of-two NUM_REQ.
    always_comb begin
        int idx;
        found   = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                found   = 1'b1;
                win_idx = PTR_W'(idx);
            end
        end
    end

    assign win_next = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    assign arb_win  = found && !tx_busy_flag;

    always_ff @(posedge system_clk) begin
        if (system_reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            data_q  <= 8'h00;
            start_q <= 1'b0;
`ifdef TX_ARB_WATCHDOG_EN
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
            start_q <= start_d;
`ifdef TX_ARB_WATCHDOG_EN
            wd_q    <= wd_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (arb_win) state_d = S_START;
            S_START:     state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (tx_complete_flag || wd_expired) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Registered outputs are computed from the transition so they line up with the new state.
    always_comb begin
        ptr_d   = ptr_q;
        grant_d = grant_q;
        data_d  = data_q;
        done_d  = '0;
        err_d   = '0;
        start_d = 1'b0;
`ifdef TX_ARB_WATCHDOG_EN
        wd_d    = wd_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (arb_win) begin
                    grant_d = NUM_REQ'(1) << win_idx;
                    data_d  = req_data[8*int'(win_idx) +: 8];
                    ptr_d   = win_next;
                    start_d = 1'b1;
                end
            end
            S_START: begin
`ifdef TX_ARB_WATCHDOG_EN
                wd_d = '0;
`endif
            end
            S_WAIT_DONE: begin
                if (tx_complete_flag) begin
                    done_d  = grant_q;
                    grant_d = '0;
                end else if (wd_expired) begin
                    err_d   = grant_q;
                    grant_d = '0;
                end else begin
`ifdef TX_ARB_WATCHDOG_EN
                    wd_d = wd_q + 1'b1;
`endif
                end
            end
            default: begin
                grant_d = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    assign grant           = grant_q;
    assign done            = done_q;
    assign error           = err_q;
    assign arb_busy        = busy_q;
    assign tx_data_byte    = data_q;
    assign tx_start_signal = start_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter with a behavioural 13-cycle UART TX controller model and an expected-grant scoreboard.
module tb_tx_arbiter;
    localparam int NR = 4;
    localparam int TO = 16;

    logic            system_clk = 1'b0;
    logic            system_reset = 1'b1;
    logic [NR-1:0]   req = '0;
    logic [8*NR-1:0] req_data = '0;
    logic [NR-1:0]   grant, done, error;
    logic            arb_busy, tx_start_signal;
    logic [7:0]      tx_data_byte;
    logic            tx_busy_flag;
    logic            tx_complete_flag;

    logic            ctl_busy = 1'b0;
    logic            force_busy = 1'b0;
    logic            no_complete = 1'b0;
    logic            ser_line = 1'b1;
    logic [7:0]      sh = 8'h00;
    int              ph = 0;

    int vectors = 0;
    int miscompares = 0;
    logic [NR-1:0] exp_grant_q[$];
    logic [7:0]    exp_byte_q[$];

    always #5 system_clk = ~system_clk;

    assign tx_busy_flag = ctl_busy | force_busy;

    tx_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
        .system_clk(system_clk), .system_reset(system_reset),
        .req(req), .req_data(req_data),
        .grant(grant), .done(done), .error(error), .arb_busy(arb_busy),
        .tx_data_byte(tx_data_byte), .tx_start_signal(tx_start_signal),
        .tx_busy_flag(tx_busy_flag), .tx_complete_flag(tx_complete_flag)
    );

    // Controller: start bit, 8 data bits LSB first, stop bit, then a one-cycle completion pulse.
    always @(posedge system_clk) begin
        if (system_reset) begin
            ph <= 0; ctl_busy <= 1'b0; tx_complete_flag <= 1'b0; ser_line <= 1'b1;
        end else begin
            tx_complete_flag <= 1'b0;
            if (ph == 0) begin
                if (tx_start_signal) begin
                    ph <= 1; ctl_busy <= 1'b1; ser_line <= 1'b0; sh <= tx_data_byte;
                end
            end else if (ph <= 8) begin
                ser_line <= sh[ph-1]; ph <= ph + 1;
            end else if (ph == 9) begin
                ser_line <= 1'b1; ph <= 10;
            end else begin
                ctl_busy <= 1'b0; tx_complete_flag <= !no_complete; ph <= 0;
            end
        end
    end

    task automatic tick();
        @(negedge system_clk);
    endtask

    // which: 0 = start pulse, 1 = done, 2 = error; n = cycles waited, -1 if never seen
    task automatic wait_for(input int which, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if ((which == 0 && tx_start_signal) || (which == 1 && done != 0) ||
                (which == 2 && error != 0)) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        logic [NR-1:0] eg;
        logic [7:0] eb;
        system_reset = 1'b1;
        req = 4'b1111;
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({grant, done, error, tx_start_signal, arb_busy, tx_data_byte} !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs: got grant=%b done=%b error=%b start=%b busy=%b byte=%h, expected all 0",
                         grant, done, error, tx_start_signal, arb_busy, tx_data_byte);
            end
        end
        exp_grant_q.push_back(4'b0001); exp_byte_q.push_back(8'h11);
        system_reset = 1'b0;
        wait_for(0, 4, n);
        vectors++;
        if (n !== 1) begin miscompares++; $display("FAIL reset_first_start: got latency %0d, expected 1", n); end
        eg = exp_grant_q.pop_front(); eb = exp_byte_q.pop_front();
        vectors++;
        if (grant !== eg || tx_data_byte !== eb) begin
            miscompares++;
            $display("FAIL reset_first_grant: got %b/%h, expected %b/%h", grant, tx_data_byte, eg, eb);
        end
        req = '0;
        wait_for(1, 20, n);
        vectors++;
        if (n !== 12 || done !== eg) begin
            miscompares++;
            $display("FAIL reset_first_done: got latency %0d done=%b, expected 12 and %b", n, done, eg);
        end
    endtask

    task automatic test_single_byte();
        int n;
        logic [NR-1:0] eg;
        logic [7:0] eb;
        logic [9:0] frame, got;
        exp_grant_q.push_back(4'b0100); exp_byte_q.push_back(8'hA5);
        req_data = {8'h00, 8'hA5, 8'h00, 8'h00};
        req = 4'b0100;
        wait_for(0, 4, n);
        eg = exp_grant_q.pop_front(); eb = exp_byte_q.pop_front();
        vectors++;
        if (n !== 1 || grant !== eg || tx_data_byte !== eb || arb_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_start: got lat=%0d grant=%b byte=%h busy=%b, expected 1/%b/%h/1",
                     n, grant, tx_data_byte, arb_busy, eg, eb);
        end
        req = '0;
        frame = {1'b1, eb, 1'b0};
        got = '0;
        for (int k = 0; k < 10; k++) begin
            tick();
            got[k] = ser_line;
        end
        vectors++;
        if (got !== frame) begin
            miscompares++;
            $display("FAIL single_serial: got %b, expected %b (bit0 first)", got, frame);
        end
        tick();
        vectors++;
        if (done !== '0) begin miscompares++; $display("FAIL single_done_early: got %b at N+12, expected 0", done); end
        tick();
        vectors++;
        if (done !== eg || grant !== '0 || arb_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_done: got done=%b grant=%b busy=%b, expected %b/0/0", done, grant, arb_busy, eg);
        end
    endtask

    task automatic test_round_robin();
        int n, starts;
        logic [NR-1:0] eg;
        logic [7:0] eb;
        system_reset = 1'b1;
        tick();
        system_reset = 1'b0;
        exp_grant_q.push_back(4'b0001); exp_byte_q.push_back(8'h11);
        exp_grant_q.push_back(4'b0010); exp_byte_q.push_back(8'h22);
        exp_grant_q.push_back(4'b1000); exp_byte_q.push_back(8'h44);
        exp_grant_q.push_back(4'b0001); exp_byte_q.push_back(8'h11);
        req_data = {8'h44, 8'h00, 8'h22, 8'h11};
        req = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            wait_for(0, 16, n);
            eg = exp_grant_q.pop_front(); eb = exp_byte_q.pop_front();
            vectors++;
            if (n !== 1 || grant !== eg || tx_data_byte !== eb) begin
                miscompares++;
                $display("FAIL rr_grant%0d: got lat=%0d grant=%b byte=%h, expected 1/%b/%h",
                         i, n, grant, tx_data_byte, eg, eb);
            end
            if (i == 3) req = '0;
            wait_for(1, 20, n);
            vectors++;
            if (n !== 12 || done !== eg) begin
                miscompares++;
                $display("FAIL rr_done%0d: got lat=%0d done=%b, expected 12/%b", i, n, done, eg);
            end
        end
        starts = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (tx_start_signal) starts++;
        end
        vectors++;
        if (starts !== 0 || exp_grant_q.size() !== 0) begin
            miscompares++;
            $display("FAIL rr_quiet: got %0d extra starts, %0d pending, expected 0/0", starts, exp_grant_q.size());
        end
    endtask

    task automatic test_ctrl_busy();
        int n, grants;
        logic [NR-1:0] eg;
        logic [7:0] eb;
        force_busy = 1'b1;
        req_data = {8'h00, 8'h00, 8'h00, 8'h5A};
        req = 4'b0001;
        grants = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (grant != 0 || tx_start_signal) grants++;
        end
        vectors++;
        if (grants !== 0) begin miscompares++; $display("FAIL busy_hold: got %0d grant cycles, expected 0", grants); end
        exp_grant_q.push_back(4'b0001); exp_byte_q.push_back(8'h5A);
        force_busy = 1'b0;
        tick();
        eg = exp_grant_q.pop_front(); eb = exp_byte_q.pop_front();
        vectors++;
        if (grant !== eg || tx_start_signal !== 1'b1 || tx_data_byte !== eb) begin
            miscompares++;
            $display("FAIL busy_release: got grant=%b start=%b byte=%h, expected %b/1/%h",
                     grant, tx_start_signal, tx_data_byte, eg, eb);
        end
        req = '0;
        wait_for(1, 20, n);
        vectors++;
        if (n !== 12 || done !== eg) begin
            miscompares++;
            $display("FAIL busy_done: got lat=%0d done=%b, expected 12/%b", n, done, eg);
        end
    endtask

    task automatic test_watchdog();
        int n;
        logic [NR-1:0] eg;
        logic [7:0] eb;
        no_complete = 1'b1;
        exp_grant_q.push_back(4'b0010); exp_byte_q.push_back(8'h77);
        req_data = {8'h00, 8'h00, 8'h77, 8'h00};
        req = 4'b0010;
        wait_for(0, 4, n);
        eg = exp_grant_q.pop_front(); eb = exp_byte_q.pop_front();
        vectors++;
        if (n !== 1 || grant !== eg || tx_data_byte !== eb) begin
            miscompares++;
            $display("FAIL wd_start: got lat=%0d grant=%b byte=%h, expected 1/%b/%h", n, grant, tx_data_byte, eg, eb);
        end
        req = '0;
`ifdef TX_ARB_WATCHDOG_EN
        wait_for(2, 3*TO, n);
        vectors++;
        if (n !== TO + 1 || error !== eg || done !== '0 || grant !== '0 || arb_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL wd_error: got lat=%0d error=%b done=%b grant=%b busy=%b, expected %0d/%b/0/0/0",
                     n, error, done, grant, arb_busy, TO + 1, eg);
        end
        tick();
        vectors++;
        if (error !== '0) begin miscompares++; $display("FAIL wd_error_pulse: got %b, expected 0", error); end
        no_complete = 1'b0;
        exp_grant_q.push_back(4'b0010); exp_byte_q.push_back(8'h77);
        req = 4'b0010;
        wait_for(0, 4, n);
        eg = exp_grant_q.pop_front(); eb = exp_byte_q.pop_front();
        req = '0;
        wait_for(1, 20, n);
        vectors++;
        if (n !== 12 || done !== eg) begin
            miscompares++;
            $display("FAIL wd_recover: got lat=%0d done=%b, expected 12/%b", n, done, eg);
        end
`else
        wait_for(1, 3*TO, n);
        vectors++;
        if (n !== -1 || grant !== eg || arb_busy !== 1'b1 || error !== '0) begin
            miscompares++;
            $display("FAIL hang_wait: got done_lat=%0d grant=%b busy=%b error=%b, expected -1/%b/1/0",
                     n, grant, arb_busy, error, eg);
        end
        system_reset = 1'b1;
        tick();
        system_reset = 1'b0;
        no_complete = 1'b0;
        vectors++;
        if (grant !== '0 || arb_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL hang_reset: got grant=%b busy=%b, expected 0/0", grant, arb_busy);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int n, pulses;
        logic [NR-1:0] eg;
        logic [7:0] eb;
        req_data = {8'h3C, 8'h00, 8'h00, 8'h00};
        req = 4'b1000;
        wait_for(0, 4, n);
        req = '0;
        repeat (5) tick();
        system_reset = 1'b1;
        tick();
        vectors++;
        if ({grant, done, error, tx_start_signal, arb_busy, tx_data_byte} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got grant=%b done=%b error=%b start=%b busy=%b byte=%h, expected all 0",
                     grant, done, error, tx_start_signal, arb_busy, tx_data_byte);
        end
        system_reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done != 0 || error != 0) pulses++;
        end
        vectors++;
        if (pulses !== 0) begin miscompares++; $display("FAIL midreset_pulses: got %0d, expected 0", pulses); end
        exp_grant_q.push_back(4'b1000); exp_byte_q.push_back(8'h3C);
        req = 4'b1000;
        wait_for(0, 4, n);
        eg = exp_grant_q.pop_front(); eb = exp_byte_q.pop_front();
        vectors++;
        if (n !== 1 || grant !== eg || tx_data_byte !== eb) begin
            miscompares++;
            $display("FAIL midreset_regrant: got lat=%0d grant=%b byte=%h, expected 1/%b/%h", n, grant, tx_data_byte, eg, eb);
        end
        req = '0;
        wait_for(1, 20, n);
        vectors++;
        if (n !== 12 || done !== eg) begin
            miscompares++;
            $display("FAIL midreset_done: got lat=%0d done=%b, expected 12/%b", n, done, eg);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_round_robin();
        test_ctrl_busy();
        test_watchdog();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d vectors applied", vectors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tx_arbiter.md
# tx_arbiter

- Round-robin scheduler that shares one UART transmit controller (byte-serial, start/busy/complete handshake) between `NUM_REQ` byte producers.
- Selects one pending requester at a time, latches its byte and pulses the controller's start input.
- Waits for the controller's completion pulse, then returns a per-requester done (or error) pulse.
- Sits between the producer blocks and the TX controller; it is the only block allowed to drive the controller's `tx_data_byte` and `tx_start_signal`.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, legal range 2..8.
- `TIMEOUT_CYCLES`, 64: watchdog limit in cycles; used only when the watchdog is compiled in.

Ports:
- `system_clk` in 1: single clock for all logic.
- `system_reset` in 1: synchronous, active-high reset.
- `req` in `NUM_REQ`: level request, one bit per requester.
- `req_data` in `8*NUM_REQ`: requester i's byte on bits `[8i+7:8i]`.
- `grant` out `NUM_REQ`: one-hot owner of the current transfer.
- `done` out `NUM_REQ`: one-cycle one-hot pulse when the owner's byte has completed.
- `error` out `NUM_REQ`: one-cycle one-hot pulse when the owner's transfer is aborted by the watchdog.
- `arb_busy` out 1: high whenever the state is not IDLE.
- `tx_data_byte` out 8: latched byte, to the controller.
- `tx_start_signal` out 1: one-cycle start pulse, to the controller.
- `tx_busy_flag` in 1: from the controller.
- `tx_complete_flag` in 1: one-cycle completion pulse from the controller.

## Operation
- All outputs are registered. Reset values: `grant`, `done`, `error`, `tx_start_signal`, `arb_busy` = 0; `tx_data_byte` = 8'h00; state = IDLE; round-robin pointer = 0.
- States are IDLE, START and WAIT_DONE.
- **IDLE**
  - Arbitrates only when `req != 0` and `tx_busy_flag == 0`. Otherwise it stays in IDLE.
  - Winner: the first set `req` bit searching upward from `ptr`, wrapping modulo `NUM_REQ`.
  - On a win: latch that requester's slice of `req_data` into `tx_data_byte`, set `grant` one-hot, set `ptr` to winner+1 (mod `NUM_REQ`), go to START.
- **START**
  - `tx_start_signal` = 1 for exactly this one cycle.
  - Go to WAIT_DONE and clear the watchdog counter.
- **WAIT_DONE**
  - On `tx_complete_flag` = 1: next cycle `done[owner]` = 1, `grant` = 0, state = IDLE.
- **Requester rules**
  - `req` is level-sensitive. A requester holds `req` and `req_data` stable until it sees `done` or `error`.
  - Deasserting `req` after a grant does not cancel the transfer.
  - `req` still high in the cycle that `done` is high counts as a new request for the byte currently on `req_data`.
- **Arbitration and pointer**
  - The IDLE cycle that carries `done` may arbitrate again, giving back-to-back transfers.
  - Because the pointer advances past the winner, a requester that holds `req` continuously never gets two consecutive grants while any other requester is pending.
- **Unexpected inputs**
  - `tx_complete_flag` outside WAIT_DONE is ignored.
- **Reset**
  - Reset mid-transfer returns all state to reset values on the next edge. No done or error pulse is generated.
- **Pointer width**
  - `ptr` is `$clog2(NUM_REQ)` bits. Wrap from `NUM_REQ-1` to 0 is explicit, which handles `NUM_REQ` values that are not a power of two.

## Timing
- Take cycle N as the IDLE cycle in which `req` is sampled high with the controller idle:
  - N+1: `grant` and `tx_start_signal` = 1.
  - N+2: `tx_busy_flag` = 1 (controller START_BIT).
  - N+3..N+10: controller data bits.
  - N+11: controller STOP.
  - N+12: `tx_complete_flag` = 1.
  - N+13: `done` = 1, state IDLE.
- Per-byte period with the controller attached is 13 cycles. Back-to-back transfers start every 13 cycles.
- `tx_data_byte` is stable from N+1 until the next arbitration win.

## Configuration
- `TX_ARB_WATCHDOG_EN` defined:
  - A counter increments on every WAIT_DONE cycle without `tx_complete_flag`.
  - If the count reaches `TIMEOUT_CYCLES-1` without completion, the next cycle has `error[owner]` = 1, `grant` = 0, state IDLE, and the pointer is already advanced.
  - Result: `error` appears `TIMEOUT_CYCLES` cycles after entering WAIT_DONE.
  - If completion arrives in the same cycle as the limit, `done` wins over `error`.
- `TX_ARB_WATCHDOG_EN` not defined:
  - No counter; WAIT_DONE waits indefinitely.
  - `error` is tied to 0. The port is still present.

## Test plan
- **Reset values:** hold reset 3 cycles with `req` = 4'b1111 → all outputs 0, no `tx_start_signal`; after release, first grant = 4'b0001.
- **Single byte:** `req[2]` = 1 with byte 8'hA5, controller attached → `tx_start_signal` at N+1; serial line shows 0,1,0,1,0,0,1,0,1,1; `done` = 4'b0100 at N+13.
- **Round-robin:** `req` = 4'b1011 held high with distinct bytes 8'h11, 8'h22 and 8'h44 → grant order 0,1,3,0, each done 13 cycles apart; bytes on `tx_data_byte` match the owner each time.
- **Controller busy:** `tx_busy_flag` forced 1 with `req[0]` = 1 → no grant until `tx_busy_flag` falls, then grant on the next cycle.
- **Watchdog** (`TX_ARB_WATCHDOG_EN`, `TIMEOUT_CYCLES` = 16, complete never asserted): `error[1]` pulses 16 cycles after WAIT_DONE entry, no `done`; a later `req[1]` is served normally.
- **Reset mid-transfer:** assert reset at N+6 → outputs return to 0 next cycle, no `done` or `error`; a fresh request afterward completes in 13 cycles.
